// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
//
// MEM-stage exception/interrupt controller. Watches the instruction in the MEM
// stage and, when it raises a synchronous exception, an ERET, or arrives while
// an enabled interrupt is pending, selects one exception code by fixed
// priority. It then hands the code, faulting PC, delay-slot flag and BadVAddr
// to CP0, and issues a one-cycle pipeline flush with the redirect target.
// After the flush the controller drains for three cycles and ignores its
// inputs, so that the redirected pipeline can refill before another event is
// accepted.
//
// Ports
//   clk                 pipeline clock, rising edge
//   rst                 synchronous active-high reset
//   inst_valid_i        MEM-stage instruction valid
//   stall_i             MEM stage stalled (nothing is sampled while set)
//   pc_i                MEM-stage instruction PC
//   in_delayslot_i      MEM instruction sits in a branch delay slot
//   exc_flags_i[8:0]    per-cause flags: [0] AdEL fetch, [1] RI, [2] Ov,
//                       [3] trap, [4] syscall, [5] break, [6] AdEL load,
//                       [7] AdES store, [8] eret
//   mem_addr_i          data address of the MEM load/store
//   status_i/cause_i/epc_i   current CP0 Status, Cause, EPC
//   excepttype_o        exception code to CP0 (nonzero for one cycle)
//   cp0_pc_o            faulting PC to CP0 (delay-slot correction is CP0's job)
//   is_in_delayslot_o   delay-slot flag to CP0
//   bad_addr_o          BadVAddr to CP0, held between address faults
//   flush_o             one-cycle pipeline flush
//   new_pc_o            redirect target, valid while flush_o is high
//   busy_o              high while the controller is not idle
// -----------------------------------------------------------------------------
module exception_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_pc_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam logic [4:0]  CODE_NONE  = 5'h00;
    localparam logic [4:0]  CODE_INT   = 5'h01;
    localparam logic [4:0]  CODE_ADEL  = 5'h04;
    localparam logic [4:0]  CODE_ADES  = 5'h05;
    localparam logic [4:0]  CODE_SYS   = 5'h08;
    localparam logic [4:0]  CODE_BP    = 5'h09;
    localparam logic [4:0]  CODE_RI    = 5'h0a;
    localparam logic [4:0]  CODE_OV    = 5'h0c;
    localparam logic [4:0]  CODE_TRAP  = 5'h0d;
    localparam logic [4:0]  CODE_ERET  = 5'h0e;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    // Source of the BadVAddr update for the selected cause.
    localparam logic [1:0]  BAD_HOLD = 2'd0;
    localparam logic [1:0]  BAD_PC   = 2'd1;
    localparam logic [1:0]  BAD_MEM  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  cnt_r;

    logic        int_pending_s;
    logic        event_s;
    logic [4:0]  code_s;
    logic [1:0]  bad_sel_s;
    logic [31:0] new_pc_s;

    // Fixed-priority cause encoder. Interrupts win over any synchronous cause
    // on the same instruction; both AdEL flavours share code 0x4.
    function automatic logic [4:0] select_code(input logic       int_pend,
                                               input logic [8:0] flags);
        logic [4:0] code;
        if (int_pend)           code = CODE_INT;
        else if (flags[0])      code = CODE_ADEL;
        else if (flags[1])      code = CODE_RI;
        else if (flags[2])      code = CODE_OV;
        else if (flags[3])      code = CODE_TRAP;
        else if (flags[4])      code = CODE_SYS;
        else if (flags[5])      code = CODE_BP;
        else if (flags[6])      code = CODE_ADEL;
        else if (flags[7])      code = CODE_ADES;
        else if (flags[8])      code = CODE_ERET;
        else                    code = CODE_NONE;
        return code;
    endfunction

    // Which address (if any) the winning cause reports as BadVAddr. Follows
    // the same priority chain so a lower-priority address fault never leaks
    // its address past a higher-priority cause.
    function automatic logic [1:0] select_bad(input logic       int_pend,
                                              input logic [8:0] flags);
        logic [1:0] sel;
        if (int_pend)               sel = BAD_HOLD;
        else if (flags[0])          sel = BAD_PC;
        else if (|flags[5:1])       sel = BAD_HOLD;
        else if (|flags[7:6])       sel = BAD_MEM;
        else                        sel = BAD_HOLD;
        return sel;
    endfunction

    // Event detection and selection of the values to be registered.
    always_comb begin
        int_pending_s = status_i[0] & ~status_i[1] &
                        (|(cause_i[15:8] & status_i[15:8]));
        event_s       = inst_valid_i & ~stall_i &
                        (int_pending_s | (|exc_flags_i));
        code_s        = select_code(int_pending_s, exc_flags_i);
        bad_sel_s     = select_bad(int_pending_s, exc_flags_i);
        if (code_s == CODE_ERET) begin
            new_pc_s = epc_i;
        end else begin
            new_pc_s = EXC_VECTOR;
        end
    end

    // Controller FSM with registered CP0/flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            cnt_r             <= 2'd0;
            excepttype_o      <= 32'd0;
            cp0_pc_o          <= 32'd0;
            is_in_delayslot_o <= 1'b0;
            bad_addr_o        <= 32'd0;
            flush_o           <= 1'b0;
            new_pc_o          <= 32'd0;
            busy_o            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (event_s) begin
                        state_r           <= ST_FLUSH;
                        excepttype_o      <= {27'd0, code_s};
                        cp0_pc_o          <= pc_i;
                        is_in_delayslot_o <= in_delayslot_i;
                        flush_o           <= 1'b1;
                        new_pc_o          <= new_pc_s;
                        busy_o            <= 1'b1;
                        case (bad_sel_s)
                            BAD_PC:  bad_addr_o <= pc_i;
                            BAD_MEM: bad_addr_o <= mem_addr_i;
                            default: bad_addr_o <= bad_addr_o;
                        endcase
                    end else begin
                        state_r      <= ST_IDLE;
                        excepttype_o <= 32'd0;
                        flush_o      <= 1'b0;
                        busy_o       <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // Counter loaded with 2 gives three DRAIN cycles (2,1,0).
                    state_r      <= ST_DRAIN;
                    cnt_r        <= 2'd2;
                    excepttype_o <= 32'd0;
                    flush_o      <= 1'b0;
                    busy_o       <= 1'b1;
                end
                ST_DRAIN: begin
                    excepttype_o <= 32'd0;
                    flush_o      <= 1'b0;
                    if (cnt_r == 2'd0) begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                        cnt_r   <= cnt_r - 2'd1;
                        busy_o  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= 2'd0;
                    excepttype_o <= 32'd0;
                    flush_o      <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

    logic        clk;
    logic        rst;
    logic        inst_valid_i;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] mem_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] excepttype_o;
    logic [31:0] cp0_pc_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    exception_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .inst_valid_i      (inst_valid_i),
        .stall_i           (stall_i),
        .pc_i              (pc_i),
        .in_delayslot_i    (in_delayslot_i),
        .exc_flags_i       (exc_flags_i),
        .mem_addr_i        (mem_addr_i),
        .status_i          (status_i),
        .cause_i           (cause_i),
        .epc_i             (epc_i),
        .excepttype_o      (excepttype_o),
        .cp0_pc_o          (cp0_pc_o),
        .is_in_delayslot_o (is_in_delayslot_o),
        .bad_addr_o        (bad_addr_o),
        .flush_o           (flush_o),
        .new_pc_o          (new_pc_o),
        .busy_o            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                        input logic [31:0] badv, input logic [31:0] npc);
        exp_t e;
        e.code = code; e.pc = pc; e.ds = ds; e.bad = badv; e.npc = npc;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        inst_valid_i   = 1'b0;
        stall_i        = 1'b0;
        pc_i           = 32'd0;
        in_delayslot_i = 1'b0;
        exc_flags_i    = 9'd0;
        mem_addr_i     = 32'd0;
        status_i       = 32'd0;
        cause_i        = 32'd0;
        epc_i          = 32'd0;
    endtask

    // One clock; check flush/busy, and on a flush compare against the oldest
    // scoreboard entry.
    task automatic tick(input string tag, input logic exp_flush, input logic exp_busy);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".flush"}, 32'(flush_o), 32'(exp_flush));
        chk({tag, ".busy"},  32'(busy_o),  32'(exp_busy));
        if (flush_o === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL %s.unexpected_flush got=%h exp=none", tag, excepttype_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, ".code"}, excepttype_o, e.code);
                chk({tag, ".pc"},   cp0_pc_o,     e.pc);
                chk({tag, ".ds"},   32'(is_in_delayslot_o), 32'(e.ds));
                chk({tag, ".bad"},  bad_addr_o,   e.bad);
                chk({tag, ".npc"},  new_pc_o,     e.npc);
            end
        end else begin
            chk({tag, ".code_zero"}, excepttype_o, 32'd0);
        end
    endtask

    task automatic drain(input string tag);
        tick({tag, ".d1"}, 1'b0, 1'b1);
        tick({tag, ".d2"}, 1'b0, 1'b1);
        tick({tag, ".d3"}, 1'b0, 1'b1);
        tick({tag, ".idle"}, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst = 1'b1;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst.code", excepttype_o, 32'd0);
        chk("rst.pc",   cp0_pc_o,     32'd0);
        chk("rst.ds",   32'(is_in_delayslot_o), 32'd0);
        chk("rst.bad",  bad_addr_o,   32'd0);
        chk("rst.flush",32'(flush_o), 32'd0);
        chk("rst.npc",  new_pc_o,     32'd0);
        chk("rst.busy", 32'(busy_o),  32'd0);
        rst = 1'b0;
        tick("idle0", 1'b0, 1'b0);

        // Syscall; a second syscall held through FLUSH/DRAIN must be ignored
        inst_valid_i = 1'b1; pc_i = 32'hBFC0_0100; exc_flags_i = 9'h010;
        push(32'h8, 32'hBFC0_0100, 1'b0, 32'd0, 32'hBFC0_0380);
        tick("sys", 1'b1, 1'b1);
        pc_i = 32'hBFC0_0104;
        drain("sys");
        clear_inputs();
        tick("sys.after", 1'b0, 1'b0);

        // RI + Ov + AdES together -> RI wins, BadVAddr untouched
        inst_valid_i = 1'b1; pc_i = 32'h8000_0010; exc_flags_i = 9'h086;
        mem_addr_i = 32'h1234_5678;
        push(32'ha, 32'h8000_0010, 1'b0, 32'd0, 32'hBFC0_0380);
        tick("ri", 1'b1, 1'b1);
        clear_inputs();
        drain("ri");

        // Interrupt masked by EXL: no event
        inst_valid_i = 1'b1; status_i = 32'h0000_FF03; cause_i = 32'h0000_0400;
        tick("exl", 1'b0, 1'b0);

        // Enabled interrupt beats the same synchronous causes; still pending
        // after the drain it is taken again on the first idle cycle.
        status_i = 32'h0000_FF01; pc_i = 32'h8000_0020; exc_flags_i = 9'h086;
        mem_addr_i = 32'h1234_5678;
        push(32'h1, 32'h8000_0020, 1'b0, 32'd0, 32'hBFC0_0380);
        tick("int", 1'b1, 1'b1);
        drain("int");
        clear_inputs();
        inst_valid_i = 1'b1; status_i = 32'h0000_FF01; cause_i = 32'h0000_0400;
        pc_i = 32'h8000_0024;
        push(32'h1, 32'h8000_0024, 1'b0, 32'd0, 32'hBFC0_0380);
        tick("int2", 1'b1, 1'b1);
        clear_inputs();
        drain("int2");

        // ERET redirects to EPC
        inst_valid_i = 1'b1; pc_i = 32'h8000_0030; exc_flags_i = 9'h100;
        epc_i = 32'hBFC0_0444;
        push(32'he, 32'h8000_0030, 1'b0, 32'd0, 32'hBFC0_0444);
        tick("eret", 1'b1, 1'b1);
        clear_inputs();
        drain("eret");

        // AdES in a delay slot
        inst_valid_i = 1'b1; pc_i = 32'h8000_0040; exc_flags_i = 9'h080;
        mem_addr_i = 32'h8000_0003; in_delayslot_i = 1'b1;
        push(32'h5, 32'h8000_0040, 1'b1, 32'h8000_0003, 32'hBFC0_0380);
        tick("ades", 1'b1, 1'b1);
        clear_inputs();
        drain("ades");

        // AdEL fetch beats AdEL load; BadVAddr takes the PC
        inst_valid_i = 1'b1; pc_i = 32'h1234_5679; exc_flags_i = 9'h041;
        mem_addr_i = 32'h0000_0002;
        push(32'h4, 32'h1234_5679, 1'b0, 32'h1234_5679, 32'hBFC0_0380);
        tick("adelf", 1'b1, 1'b1);
        clear_inputs();
        drain("adelf");

        // AdEL load; BadVAddr takes the data address
        inst_valid_i = 1'b1; pc_i = 32'h8000_0050; exc_flags_i = 9'h040;
        mem_addr_i = 32'h8000_0101;
        push(32'h4, 32'h8000_0050, 1'b0, 32'h8000_0101, 32'hBFC0_0380);
        tick("adell", 1'b1, 1'b1);
        clear_inputs();
        drain("adell");

        // Syscall under stall for two cycles, taken once stall drops
        inst_valid_i = 1'b1; pc_i = 32'h8000_0060; exc_flags_i = 9'h010;
        stall_i = 1'b1;
        tick("stall1", 1'b0, 1'b0);
        tick("stall2", 1'b0, 1'b0);
        stall_i = 1'b0;
        push(32'h8, 32'h8000_0060, 1'b0, 32'h8000_0101, 32'hBFC0_0380);
        tick("stall.take", 1'b1, 1'b1);
        clear_inputs();
        drain("stall");

        // Break, then reset in the middle of DRAIN
        inst_valid_i = 1'b1; pc_i = 32'h8000_0070; exc_flags_i = 9'h020;
        push(32'h9, 32'h8000_0070, 1'b0, 32'h8000_0101, 32'hBFC0_0380);
        tick("brk", 1'b1, 1'b1);
        clear_inputs();
        tick("brk.d1", 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2.code", excepttype_o, 32'd0);
        chk("rst2.pc",   cp0_pc_o,     32'd0);
        chk("rst2.ds",   32'(is_in_delayslot_o), 32'd0);
        chk("rst2.bad",  bad_addr_o,   32'd0);
        chk("rst2.flush",32'(flush_o), 32'd0);
        chk("rst2.npc",  new_pc_o,     32'd0);
        chk("rst2.busy", 32'(busy_o),  32'd0);
        rst = 1'b0;
        tick("post_rst1", 1'b0, 1'b0);
        tick("post_rst2", 1'b0, 1'b0);
        tick("post_rst3", 1'b0, 1'b0);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
